rx_frame_tx_seq: RTL and testbench

- Downstream consumer of the UART RX frame buffer.
- On a frame-complete pulse it reads FRAME_LEN bytes from the buffer's read port, starting at a captured base address.
- Each byte goes to the uart_tx instance through its DV/Done handshake, so a received frame is echoed back out.
- Adds per-byte watchdog, overrun detection and frame-level status pulses.

---
 rtl/rx_frame_tx_seq.sv | 154 +++++++++++++++
 tb/tb_rx_frame_tx_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_tx_seq.sv
// Frame echo sequencer: reads a received frame out of the RX buffer
// and feeds it byte by byte to uart_tx, with watchdog and overrun flags.
module rx_frame_tx_seq #(
  parameter int FRAME_LEN  = 10,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_frame_done,
  input  logic [ADDR_W-1:0] i_frame_base,
  output logic              o_mem_r_en,
  output logic [ADDR_W-1:0] o_mem_r_addr,
  input  logic [DATA_W-1:0] i_mem_r_data,
  output logic              o_tx_dv,
  output logic [DATA_W-1:0] o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_byte_idx,
  output logic              o_frame_sent,
  output logic              o_overrun,
  output logic              o_timeout
);

  localparam int WD_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(FRAME_LEN - 1);
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_START,
    S_TX_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic                tx_dv_q, tx_dv_d;
  logic                busy_q, busy_d;
  logic                sent_q, sent_d;
  logic                ovr_q, ovr_d;
  logic                to_q, to_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    addr_d    = addr_q;
    tx_byte_d = tx_byte_q;
    wdog_d    = wdog_q;
    to_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_frame_done) begin
          base_d  = i_frame_base;
          idx_d   = '0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        tx_byte_d = i_mem_r_data;
        state_d   = S_TX_START;
      end
      S_TX_START: begin
        if (!i_tx_active) begin
          wdog_d  = '0;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // done beats a watchdog expiry in the same cycle
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_RD_REQ;
          end
        end else if (wdog_q == WD_MAX) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) idx_d = '0;

    // outputs registered from the next state
    mem_r_en_d = (state_d == S_RD_REQ);
    if (mem_r_en_d) addr_d = base_d + idx_d;
    tx_dv_d = (state_q == S_TX_START) &&
              (state_d == S_TX_WAIT);
    sent_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ovr_d   = i_frame_done && (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      tx_byte_q  <= '0;
      wdog_q     <= '0;
      mem_r_en_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      tx_byte_q  <= tx_byte_d;
      wdog_q     <= wdog_d;
      mem_r_en_q <= mem_r_en_d;
      tx_dv_q    <= tx_dv_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
    end
  end

  assign o_mem_r_en   = mem_r_en_q;
  assign o_mem_r_addr = addr_q;
  assign o_tx_dv      = tx_dv_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_byte_idx   = idx_q;
  assign o_frame_sent = sent_q;
  assign o_overrun    = ovr_q;
  assign o_timeout    = to_q;

endmodule

// File: tb/tb_rx_frame_tx_seq.sv
// Bench for rx_frame_tx_seq: cycle vectors plus frame-level
// scenarios against a buffer model and a uart_tx model.
module tb_rx_frame_tx_seq;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_frame_done;
  logic [9:0] i_frame_base;
  logic       o_mem_r_en;
  logic [9:0] o_mem_r_addr;
  logic [7:0] i_mem_r_data;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_active;
  logic       i_tx_done;
  logic       o_busy;
  logic [9:0] o_byte_idx;
  logic       o_frame_sent;
  logic       o_overrun;
  logic       o_timeout;

  rx_frame_tx_seq #(
    .FRAME_LEN(10), .ADDR_W(10),
    .DATA_W(8), .TX_TIMEOUT(64)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .i_frame_done(i_frame_done),
    .i_frame_base(i_frame_base),
    .o_mem_r_en(o_mem_r_en),
    .o_mem_r_addr(o_mem_r_addr),
    .i_mem_r_data(i_mem_r_data),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .i_tx_active(i_tx_active),
    .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_byte_idx(o_byte_idx),
    .o_frame_sent(o_frame_sent),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer model: synchronous read
  logic [7:0] mem [1024];
  always @(posedge clk)
    if (o_mem_r_en) i_mem_r_data <= mem[o_mem_r_addr];

  // uart_tx model: done 20 cycles after dv
  logic manual, m_act, m_done, respond, force_act;
  logic model_run, model_done;
  int   model_cnt;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (i_rst) begin
      model_run <= 1'b0;
      model_cnt <= 0;
    end else if (o_tx_dv) begin
      model_run <= 1'b1;
      model_cnt <= 1;
    end else if (model_run) begin
      if (model_cnt == 20) begin
        model_run  <= 1'b0;
        model_done <= respond;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end
  assign i_tx_done   = manual ? m_done : model_done;
  assign i_tx_active = manual ? m_act
                              : (model_run | force_act);

  // monitor
  logic [7:0] byte_q[$];
  logic [9:0] addr_q[$];
  int dv_cnt, sent_cnt, ovr_cnt, to_cnt;
  int first_dv_cyc, to_cyc, done_edge, gap_n, gap_bad;
  always @(negedge clk) begin
    if (i_tx_done) done_edge = cyc + 1;
    if (o_tx_dv) begin
      byte_q.push_back(o_tx_byte);
      if (dv_cnt == 0) first_dv_cyc = cyc;
      else begin
        gap_n++;
        if (cyc - done_edge != 3) gap_bad++;
      end
      dv_cnt++;
    end
    if (o_mem_r_en) addr_q.push_back(o_mem_r_addr);
    if (o_frame_sent) sent_cnt++;
    if (o_overrun) ovr_cnt++;
    if (o_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [33:0] outs();
    return {o_mem_r_en, o_mem_r_addr, o_tx_dv,
            o_tx_byte, o_busy, o_byte_idx,
            o_overrun, o_frame_sent, o_timeout};
  endfunction

  task automatic clear();
    byte_q.delete();
    addr_q.delete();
    dv_cnt = 0; sent_cnt = 0;
    ovr_cnt = 0; to_cnt = 0;
    gap_n = 0; gap_bad = 0;
    first_dv_cyc = -1; to_cyc = -1;
  endtask

  int t_fd;
  task automatic start_frame(input logic [9:0] b);
    i_frame_done = 1'b1;
    i_frame_base = b;
    @(posedge clk); #1;
    t_fd = cyc;
    i_frame_done = 1'b0;
    i_frame_base = '0;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (sent_cnt == 0 && to_cnt == 0 && n < 1500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_end_seen"}, 64'(n >= 1500), 0);
  endtask

  task automatic chk_frame(input string nm,
                           input logic [9:0] b,
                           input logic [7:0] d0);
    chk({nm, "_nbytes"}, byte_q.size(), 10);
    chk({nm, "_naddr"}, addr_q.size(), 10);
    for (int i = 0; i < byte_q.size(); i++)
      chk({nm, "_byte"}, byte_q[i], d0 + 8'(i));
    for (int i = 0; i < addr_q.size(); i++)
      chk({nm, "_addr"}, addr_q[i], b + 10'(i));
    chk({nm, "_sent"}, sent_cnt, 1);
  endtask

  typedef struct {
    logic fd; logic [9:0] base;
    logic act; logic done;
    logic en; logic [9:0] addr; logic dv;
    logic [7:0] byt; logic busy;
    logic [9:0] idx; logic ovr;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] a;
    int rel, n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 8'h55; mem[6] = 8'h66;
    i_rst = 1'b1; i_frame_done = 1'b0;
    i_frame_base = '0;
    manual = 1'b1; m_act = 1'b0; m_done = 1'b0;
    respond = 1'b1; force_act = 1'b0;
    clear();

    //          fd base   act done en addr  dv byte   bsy idx   ovr
    tbl[0]  = '{1, 10'd5, 0, 0, 1, 10'd5, 0, 8'h00, 1, 10'd0, 0};
    tbl[1]  = '{0, 10'd0, 0, 0, 0, 10'd5, 0, 8'h00, 1, 10'd0, 0};
    tbl[2]  = '{0, 10'd0, 0, 0, 0, 10'd5, 0, 8'h55, 1, 10'd0, 0};
    tbl[3]  = '{0, 10'd0, 0, 0, 0, 10'd5, 1, 8'h55, 1, 10'd0, 0};
    tbl[4]  = '{0, 10'd0, 0, 0, 0, 10'd5, 0, 8'h55, 1, 10'd0, 0};
    tbl[5]  = '{0, 10'd0, 0, 1, 1, 10'd6, 0, 8'h55, 1, 10'd1, 0};
    tbl[6]  = '{0, 10'd0, 0, 1, 0, 10'd6, 0, 8'h55, 1, 10'd1, 0};
    tbl[7]  = '{0, 10'd0, 1, 0, 0, 10'd6, 0, 8'h66, 1, 10'd1, 0};
    tbl[8]  = '{0, 10'd0, 1, 0, 0, 10'd6, 0, 8'h66, 1, 10'd1, 0};
    tbl[9]  = '{0, 10'd0, 0, 0, 0, 10'd6, 1, 8'h66, 1, 10'd1, 0};
    tbl[10] = '{1, 10'h3ff, 0, 0, 0, 10'd6, 0, 8'h66, 1, 10'd1, 1};
    tbl[11] = '{0, 10'd0, 0, 0, 0, 10'd6, 0, 8'h66, 1, 10'd1, 0};
    tbl[12] = '{0, 10'd0, 0, 1, 1, 10'd7, 0, 8'h66, 1, 10'd2, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    i_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      i_frame_done = tbl[i].fd;
      i_frame_base = tbl[i].base;
      m_act = tbl[i].act;
      m_done = tbl[i].done;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].en, tbl[i].addr, tbl[i].dv,
           tbl[i].byt, tbl[i].busy, tbl[i].idx,
           tbl[i].ovr, 2'b00});
    end
    i_frame_done = 1'b0; m_done = 1'b0; m_act = 1'b0;
    i_rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_after_vec", outs(), 0);
    i_rst = 1'b0;
    manual = 1'b0;
    @(posedge clk); #1;

    // basic echo
    for (int i = 0; i < 10; i++) mem[i] = 8'h30 + 8'(i);
    clear();
    start_frame(10'd0);
    wait_end("echo");
    chk_frame("echo", 10'd0, 8'h30);
    chk("echo_dv_cnt", dv_cnt, 10);
    chk("echo_first_dv_lat", first_dv_cyc - t_fd, 3);
    chk("echo_gap_n", gap_n, 9);
    chk("echo_gap_bad", gap_bad, 0);
    chk("echo_idle", {o_busy, o_byte_idx}, 0);

    // address wrap
    for (int i = 0; i < 4; i++) mem[1020 + i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) mem[i] = 8'hB0 + 8'(i);
    clear();
    start_frame(10'd1020);
    wait_end("wrap");
    chk("wrap_nbytes", byte_q.size(), 10);
    chk("wrap_naddr", addr_q.size(), 10);
    for (int i = 0; i < addr_q.size(); i++) begin
      a = 10'd1020 + 10'(i);
      chk("wrap_addr", addr_q[i], a);
    end
    for (int i = 0; i < byte_q.size(); i++)
      chk("wrap_byte", byte_q[i],
          i < 4 ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i - 4));
    chk("wrap_sent", sent_cnt, 1);

    // overrun
    for (int i = 0; i < 10; i++) mem[600 + i] = 8'h60 + 8'(i);
    clear();
    start_frame(10'd600);
    repeat (49) @(posedge clk);
    #1;
    i_frame_done = 1'b1;
    i_frame_base = 10'd0;
    @(posedge clk); #1;
    i_frame_done = 1'b0;
    chk("ovr_pulse", o_overrun, 1);
    @(posedge clk); #1;
    chk("ovr_pulse_end", o_overrun, 0);
    wait_end("ovr");
    chk_frame("ovr", 10'd600, 8'h60);
    chk("ovr_cnt", ovr_cnt, 1);

    // busy uart holds TX_START
    for (int i = 0; i < 10; i++) mem[500 + i] = 8'hC0 + 8'(i);
    clear();
    force_act = 1'b1;
    start_frame(10'd500);
    repeat (100) @(posedge clk);
    #1;
    chk("busy_no_dv", dv_cnt, 0);
    chk("busy_byte_held", o_tx_byte, 8'hC0);
    force_act = 1'b0;
    rel = cyc;
    n = 0;
    while (dv_cnt == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_dv_lat", first_dv_cyc - rel, 1);
    wait_end("busy");
    chk_frame("busy", 10'd500, 8'hC0);

    // watchdog timeout, then a normal frame
    for (int i = 0; i < 10; i++) mem[200 + i] = 8'h20 + 8'(i);
    clear();
    respond = 1'b0;
    start_frame(10'd200);
    wait_end("to");
    chk("to_cnt", to_cnt, 1);
    chk("to_lat", to_cyc - first_dv_cyc, 64);
    chk("to_busy", o_busy, 0);
    chk("to_sent", sent_cnt, 0);
    chk("to_dv_cnt", dv_cnt, 1);
    respond = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    clear();
    start_frame(10'd200);
    wait_end("after_to");
    chk_frame("after_to", 10'd200, 8'h20);
    chk("after_to_tcnt", to_cnt, 0);

    // reset during byte 4
    for (int i = 0; i < 10; i++) mem[300 + i] = 8'h70 + 8'(i);
    for (int i = 0; i < 10; i++) mem[400 + i] = 8'h90 + 8'(i);
    clear();
    start_frame(10'd300);
    n = 0;
    while (dv_cnt < 5 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_idx", o_byte_idx, 4);
    i_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outs", outs(), 0);
    i_rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_end", sent_cnt + to_cnt, 0);
    chk("rst_mid_nbytes", byte_q.size(), 5);
    clear();
    start_frame(10'd400);
    wait_end("rst_new");
    chk_frame("rst_new", 10'd400, 8'h90);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
